// File: rtl/vproc_dispatcher.sv
// In-order single-entry dispatcher: buffers one decoded vector instruction, tracks
// pending register-group writes and releases the instruction once RAW/WAW/drain clear.
module vproc_dispatcher #(
    parameter int unsigned UNIT_CNT = 5,
    parameter int unsigned OP_W     = 13,
    parameter int unsigned STALL_W  = 16
) (
    input  logic                clk_i,
    input  logic                sync_rst_ni,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [2:0]          instr_unit_i,
    input  logic [OP_W-1:0]     instr_mode_i,
    input  logic [1:0]          instr_emul_i,
    input  logic                instr_vs1_vreg_i,
    input  logic                instr_vs2_vreg_i,
    input  logic                instr_vd_vreg_i,
    input  logic [4:0]          instr_vs1_i,
    input  logic [4:0]          instr_vs2_i,
    input  logic [4:0]          instr_vd_i,
    input  logic [UNIT_CNT-1:0] unit_ready_i,
    input  logic [UNIT_CNT-1:0] units_idle_i,
    input  logic [31:0]         wr_clear_i,
    output logic [UNIT_CNT-1:0] disp_valid_o,
    output logic [OP_W-1:0]     disp_mode_o,
    output logic [1:0]          disp_emul_o,
    output logic [4:0]          disp_vs1_o,
    output logic [4:0]          disp_vs2_o,
    output logic [4:0]          disp_vd_o,
    output logic                cfg_valid_o,
    output logic [31:0]         pend_wr_o,
    output logic [STALL_W-1:0]  stall_cnt_o
);

    localparam logic [2:0] UNIT_CFG   = 3'd5;
    localparam logic [2:0] UNIT_CNT_L = 3'(UNIT_CNT);

    // Register group of 2^e registers containing a: same address bits above e.
    function automatic logic [31:0] f_grp(input logic [4:0] a, input logic [1:0] e);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = ((5'(i) >> e) == (a >> e));
        end
        return m;
    endfunction

    logic                r_buf_valid;
    logic [2:0]          r_unit;
    logic [OP_W-1:0]     r_mode;
    logic [1:0]          r_emul;
    logic                r_vs1_vreg;
    logic                r_vs2_vreg;
    logic                r_vd_vreg;
    logic [4:0]          r_vs1;
    logic [4:0]          r_vs2;
    logic [4:0]          r_vd;
    logic [31:0]         r_pend;
    logic [STALL_W-1:0]  r_stall_cnt;

    logic                w_is_cfg;
    logic                w_legal;
    logic                w_haz;
    logic                w_drained;
    logic [UNIT_CNT-1:0] w_disp_valid;
    logic                w_fire_unit;
    logic                w_fire_cfg;
    logic                w_fire;
    logic                w_accept;
    logic                w_stall;
    logic [31:0]         w_pend_set;
    logic [31:0]         w_pend_next;

    assign w_is_cfg  = (r_unit == UNIT_CFG);
    assign w_legal   = (r_unit < UNIT_CNT_L);
    assign w_drained = (r_pend == '0) & (&units_idle_i);

    // Hazards use the registered bitmap only, so a clear takes effect one cycle later.
    assign w_haz = (r_vs1_vreg & |(f_grp(r_vs1, r_emul) & r_pend))
                 | (r_vs2_vreg & |(f_grp(r_vs2, r_emul) & r_pend))
                 | (r_vd_vreg  & |(f_grp(r_vd,  r_emul) & r_pend));

    always_comb begin
        w_disp_valid = '0;
        for (int u = 0; u < int'(UNIT_CNT); u++) begin
            w_disp_valid[u] = r_buf_valid & ~w_is_cfg & ~w_haz & (r_unit == 3'(u));
        end
    end

    assign w_fire_unit = |(w_disp_valid & unit_ready_i);
    assign w_fire_cfg  = r_buf_valid & w_is_cfg & w_drained;
    assign w_fire      = w_fire_unit | w_fire_cfg;
    assign w_accept    = instr_valid_i & instr_ready_o;

    // Unit backpressure alone is not a stall worth counting.
    assign w_stall = r_buf_valid & ~w_fire & (w_is_cfg ? ~w_drained : w_haz);

    assign w_pend_set  = (w_fire_unit & r_vd_vreg) ? f_grp(r_vd, r_emul) : '0;
    assign w_pend_next = (r_pend & ~wr_clear_i) | w_pend_set;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_buf_valid <= 1'b0;
            r_unit      <= '0;
            r_mode      <= '0;
            r_emul      <= '0;
            r_vs1_vreg  <= 1'b0;
            r_vs2_vreg  <= 1'b0;
            r_vd_vreg   <= 1'b0;
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_vd        <= '0;
        end else if (w_accept) begin
            r_buf_valid <= 1'b1;
            r_unit      <= instr_unit_i;
            r_mode      <= instr_mode_i;
            r_emul      <= instr_emul_i;
            r_vs1_vreg  <= instr_vs1_vreg_i;
            r_vs2_vreg  <= instr_vs2_vreg_i;
            r_vd_vreg   <= instr_vd_vreg_i;
            r_vs1       <= instr_vs1_i;
            r_vs2       <= instr_vs2_i;
            r_vd        <= instr_vd_i;
        end else if (w_fire) begin
            r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_pend      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign instr_ready_o = ~r_buf_valid | w_fire;
    assign disp_valid_o  = w_disp_valid;
    assign cfg_valid_o   = w_fire_cfg;
    assign disp_mode_o   = r_mode;
    assign disp_emul_o   = r_emul;
    assign disp_vs1_o    = r_vs1;
    assign disp_vs2_o    = r_vs2;
    assign disp_vd_o     = r_vd;
    assign pend_wr_o     = r_pend;
    assign stall_cnt_o   = r_stall_cnt;

    a_no_illegal_unit: assert property (@(posedge clk_i) disable iff (!sync_rst_ni)
        !(r_buf_valid && !w_is_cfg && !w_legal));

    a_disp_stable: assert property (@(posedge clk_i) disable iff (!sync_rst_ni)
        (|w_disp_valid && !w_fire) |=> (disp_valid_o == $past(disp_valid_o)) && $stable(r_mode));

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Self-checking bench for vproc_dispatcher: directed scenarios plus a random run
// compared cycle by cycle against a behavioural model of the dispatch rules.
module tb_vproc_dispatcher;

    logic        clk = 1'b0;
    logic        sync_rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [2:0]  instr_unit_i;
    logic [12:0] instr_mode_i;
    logic [1:0]  instr_emul_i;
    logic        instr_vs1_vreg_i, instr_vs2_vreg_i, instr_vd_vreg_i;
    logic [4:0]  instr_vs1_i, instr_vs2_i, instr_vd_i;
    logic [4:0]  unit_ready_i, units_idle_i;
    logic [31:0] wr_clear_i;
    logic [4:0]  disp_valid_o;
    logic [12:0] disp_mode_o;
    logic [1:0]  disp_emul_o;
    logic [4:0]  disp_vs1_o, disp_vs2_o, disp_vd_o;
    logic        cfg_valid_o;
    logic [31:0] pend_wr_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vproc_dispatcher #(.UNIT_CNT(5), .OP_W(13), .STALL_W(16)) dut (
        .clk_i(clk), .sync_rst_ni(sync_rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_unit_i(instr_unit_i), .instr_mode_i(instr_mode_i), .instr_emul_i(instr_emul_i),
        .instr_vs1_vreg_i(instr_vs1_vreg_i), .instr_vs2_vreg_i(instr_vs2_vreg_i),
        .instr_vd_vreg_i(instr_vd_vreg_i),
        .instr_vs1_i(instr_vs1_i), .instr_vs2_i(instr_vs2_i), .instr_vd_i(instr_vd_i),
        .unit_ready_i(unit_ready_i), .units_idle_i(units_idle_i), .wr_clear_i(wr_clear_i),
        .disp_valid_o(disp_valid_o), .disp_mode_o(disp_mode_o), .disp_emul_o(disp_emul_o),
        .disp_vs1_o(disp_vs1_o), .disp_vs2_o(disp_vs2_o), .disp_vd_o(disp_vd_o),
        .cfg_valid_o(cfg_valid_o), .pend_wr_o(pend_wr_o), .stall_cnt_o(stall_cnt_o)
    );

    // ---------------- behavioural model ----------------
    bit          m_bv;
    logic [2:0]  m_unit;
    logic [12:0] m_mode;
    logic [1:0]  m_emul;
    bit          m_vs1v, m_vs2v, m_vdv;
    logic [4:0]  m_vs1, m_vs2, m_vd;
    logic [31:0] m_pend;
    logic [15:0] m_stall;
    bit          e_ready, e_cfg, e_fire, e_isc, e_haz, e_drained;
    logic [4:0]  e_disp;

    // Group of 2^e registers, base address rounded down to a multiple of the size.
    function automatic logic [31:0] grp(input logic [4:0] a, input logic [1:0] e);
        int sz;
        int base;
        logic [63:0] m;
        sz = 1 << e;
        base = (int'(a) / sz) * sz;
        m = ((64'd1 << sz) - 64'd1) << base;
        return m[31:0];
    endfunction

    task automatic model_comb();
        e_isc = (m_unit == 3'd5);
        e_haz = (m_vs1v && ((grp(m_vs1, m_emul) & m_pend) != 0))
             || (m_vs2v && ((grp(m_vs2, m_emul) & m_pend) != 0))
             || (m_vdv  && ((grp(m_vd,  m_emul) & m_pend) != 0));
        e_drained = (m_pend == 0) && (units_idle_i == 5'h1F);
        e_disp = '0;
        e_cfg = 0;
        e_fire = 0;
        if (m_bv) begin
            if (e_isc) begin
                e_fire = e_drained;
                e_cfg = e_drained;
            end else if (!e_haz && int'(m_unit) < 5) begin
                e_disp[int'(m_unit)] = 1'b1;
                e_fire = unit_ready_i[int'(m_unit)];
            end
        end
        e_ready = !m_bv || e_fire;
    endtask

    task automatic model_seq();
        logic [31:0] np;
        model_comb();
        if (!sync_rst_ni) begin
            m_bv = 0; m_unit = 0; m_mode = 0; m_emul = 0;
            m_vs1v = 0; m_vs2v = 0; m_vdv = 0; m_vs1 = 0; m_vs2 = 0; m_vd = 0;
            m_pend = 0; m_stall = 0;
        end else begin
            np = (m_pend & ~wr_clear_i) | ((e_fire && !e_isc && m_vdv) ? grp(m_vd, m_emul) : 32'h0);
            if (m_bv && !e_fire && (e_isc ? !e_drained : e_haz) && m_stall != 16'hFFFF)
                m_stall = m_stall + 16'd1;
            if (instr_valid_i && e_ready) begin
                m_bv = 1; m_unit = instr_unit_i; m_mode = instr_mode_i; m_emul = instr_emul_i;
                m_vs1v = instr_vs1_vreg_i; m_vs2v = instr_vs2_vreg_i; m_vdv = instr_vd_vreg_i;
                m_vs1 = instr_vs1_i; m_vs2 = instr_vs2_i; m_vd = instr_vd_i;
            end else if (e_fire) begin
                m_bv = 0;
            end
            m_pend = np;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic settle(); @(negedge clk); model_comb(); endtask
    task automatic edge_();  @(posedge clk); model_seq(); #1; endtask
    task automatic cyc();    settle(); edge_(); endtask

    task automatic drive(input bit v, input int unit, input int emul,
                         input bit v1v, input int v1, input bit v2v, input int v2,
                         input bit vdv, input int vd, input logic [12:0] mode);
        instr_valid_i = v; instr_unit_i = 3'(unit); instr_emul_i = 2'(emul);
        instr_vs1_vreg_i = v1v; instr_vs1_i = 5'(v1);
        instr_vs2_vreg_i = v2v; instr_vs2_i = 5'(v2);
        instr_vd_vreg_i = vdv;  instr_vd_i = 5'(vd);
        instr_mode_i = mode;
    endtask

    task automatic do_reset();
        sync_rst_ni = 0; instr_valid_i = 0; wr_clear_i = 0;
        unit_ready_i = '1; units_idle_i = '1;
        cyc(); cyc();
        sync_rst_ni = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if (instr_ready_o !== 1'b1 || disp_valid_o !== 5'b0 || pend_wr_o !== 32'h0 ||
            stall_cnt_o !== 16'h0 || cfg_valid_o !== 1'b0 || disp_vd_o !== 5'h0 || disp_mode_o !== 13'h0) begin
            failures++;
            $display("FAIL reset_initial: ready=%b disp=%b pend=%h stall=%h cfg=%b vd=%h mode=%h required 1/0/0/0/0/0/0",
                     instr_ready_o, disp_valid_o, pend_wr_o, stall_cnt_o, cfg_valid_o, disp_vd_o, disp_mode_o);
        end
        edge_();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 2, 13'h0AA);
        cyc();
        instr_valid_i = 0;
        cyc();
        drive(1, 0, 0, 1, 2, 0, 0, 0, 0, 13'h055);
        cyc();
        instr_valid_i = 0;
        settle();
        checks++;
        if (pend_wr_o !== 32'h4 || disp_valid_o !== 5'b0) begin
            failures++;
            $display("FAIL reset_preload: pend=%h disp=%b required 00000004/00000", pend_wr_o, disp_valid_o);
        end
        edge_();
        sync_rst_ni = 0;
        cyc(); cyc();
        sync_rst_ni = 1;
        settle();
        checks++;
        if (instr_ready_o !== 1'b1 || disp_valid_o !== 5'b0 || pend_wr_o !== 32'h0 ||
            stall_cnt_o !== 16'h0 || cfg_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop: ready=%b disp=%b pend=%h stall=%h cfg=%b required 1/0/0/0/0",
                     instr_ready_o, disp_valid_o, pend_wr_o, stall_cnt_o, cfg_valid_o);
        end
        edge_();
    endtask

    task automatic test_streaming();
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 4, 13'h011);
        cyc();
        drive(1, 2, 0, 0, 0, 1, 8, 1, 8, 13'h022);
        settle();
        checks++;
        if (disp_valid_o !== 5'b00010 || instr_ready_o !== 1'b1 || disp_vd_o !== 5'd4) begin
            failures++;
            $display("FAIL stream_alu: disp=%b ready=%b vd=%0d required 00010/1/4", disp_valid_o, instr_ready_o, disp_vd_o);
        end
        edge_();
        instr_valid_i = 0;
        settle();
        checks++;
        if (disp_valid_o !== 5'b00100 || pend_wr_o !== 32'h10 || disp_mode_o !== 13'h022) begin
            failures++;
            $display("FAIL stream_mul: disp=%b pend=%h mode=%h required 00100/00000010/0022", disp_valid_o, pend_wr_o, disp_mode_o);
        end
        edge_();
        settle();
        checks++;
        if (pend_wr_o !== 32'h110 || disp_valid_o !== 5'b0) begin
            failures++;
            $display("FAIL stream_pend: pend=%h disp=%b required 00000110/00000", pend_wr_o, disp_valid_o);
        end
        edge_();
    endtask

    task automatic test_raw();
        do_reset();
        drive(1, 0, 2, 0, 0, 0, 0, 1, 8, 13'h100);
        cyc();
        drive(1, 1, 0, 1, 10, 0, 0, 1, 20, 13'h101);
        settle();
        checks++;
        if (disp_valid_o !== 5'b00001) begin
            failures++;
            $display("FAIL raw_lsu_disp: disp=%b required 00001", disp_valid_o);
        end
        edge_();
        instr_valid_i = 0;
        settle();
        checks++;
        if (pend_wr_o !== 32'h0F00 || disp_valid_o !== 5'b0 || stall_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL raw_blocked: pend=%h disp=%b stall=%0d required 00000f00/00000/0", pend_wr_o, disp_valid_o, stall_cnt_o);
        end
        edge_();
        for (int k = 1; k <= 4; k++) begin
            settle();
            checks++;
            if (stall_cnt_o !== 16'(k) || disp_valid_o !== 5'b0) begin
                failures++;
                $display("FAIL raw_stall_count: stall=%0d disp=%b required %0d/00000", stall_cnt_o, disp_valid_o, k);
            end
            edge_();
        end
        wr_clear_i = 32'h0F00;
        settle();
        checks++;
        if (disp_valid_o !== 5'b0 || stall_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL raw_clear_same_cycle: disp=%b stall=%0d required 00000/5", disp_valid_o, stall_cnt_o);
        end
        edge_();
        wr_clear_i = 0;
        settle();
        checks++;
        if (disp_valid_o !== 5'b00010 || pend_wr_o !== 32'h0 || stall_cnt_o !== 16'd6) begin
            failures++;
            $display("FAIL raw_clear_next_cycle: disp=%b pend=%h stall=%0d required 00010/0/6", disp_valid_o, pend_wr_o, stall_cnt_o);
        end
        edge_();
        settle();
        checks++;
        if (pend_wr_o !== 32'h0010_0000 || disp_valid_o !== 5'b0) begin
            failures++;
            $display("FAIL raw_after_fire: pend=%h disp=%b required 00100000/00000", pend_wr_o, disp_valid_o);
        end
        edge_();
    endtask

    task automatic test_waw();
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 13'h033);
        cyc();
        instr_valid_i = 0;
        cyc();
        drive(1, 2, 0, 0, 0, 0, 0, 1, 0, 13'h044);
        cyc();
        instr_valid_i = 0;
        settle();
        checks++;
        if (pend_wr_o !== 32'h1 || disp_valid_o !== 5'b0) begin
            failures++;
            $display("FAIL waw_blocked: pend=%h disp=%b required 00000001/00000", pend_wr_o, disp_valid_o);
        end
        edge_();
        wr_clear_i = 32'h1;
        cyc();
        settle();
        checks++;
        if (disp_valid_o !== 5'b00100 || pend_wr_o !== 32'h0) begin
            failures++;
            $display("FAIL waw_release: disp=%b pend=%h required 00100/0", disp_valid_o, pend_wr_o);
        end
        edge_();
        wr_clear_i = 0;
        settle();
        checks++;
        if (pend_wr_o !== 32'h1) begin
            failures++;
            $display("FAIL waw_set_wins: pend=%h required 00000001", pend_wr_o);
        end
        edge_();
    endtask

    task automatic test_cfg_drain();
        do_reset();
        drive(1, 2, 0, 0, 0, 0, 0, 1, 2, 13'h055);
        cyc();
        instr_valid_i = 0;
        cyc();
        units_idle_i = 5'b11011;
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 13'h066);
        settle();
        checks++;
        if (pend_wr_o !== 32'h4) begin
            failures++;
            $display("FAIL cfg_pend_setup: pend=%h required 00000004", pend_wr_o);
        end
        edge_();
        instr_valid_i = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (cfg_valid_o !== 1'b0 || disp_valid_o !== 5'b0 || instr_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL cfg_wait_pend: cfg=%b disp=%b ready=%b required 0/00000/0", cfg_valid_o, disp_valid_o, instr_ready_o);
            end
            edge_();
        end
        wr_clear_i = 32'h4;
        cyc();
        wr_clear_i = 0;
        settle();
        checks++;
        if (pend_wr_o !== 32'h0 || cfg_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL cfg_wait_idle: pend=%h cfg=%b required 0/0", pend_wr_o, cfg_valid_o);
        end
        edge_();
        units_idle_i = '1;
        drive(1, 1, 0, 0, 0, 0, 0, 1, 6, 13'h077);
        settle();
        checks++;
        if (cfg_valid_o !== 1'b1 || disp_valid_o !== 5'b0 || instr_ready_o !== 1'b1 || stall_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL cfg_fire: cfg=%b disp=%b ready=%b stall=%0d required 1/00000/1/5",
                     cfg_valid_o, disp_valid_o, instr_ready_o, stall_cnt_o);
        end
        edge_();
        instr_valid_i = 0;
        settle();
        checks++;
        if (cfg_valid_o !== 1'b0 || disp_valid_o !== 5'b00010 || disp_vd_o !== 5'd6) begin
            failures++;
            $display("FAIL cfg_pulse_next: cfg=%b disp=%b vd=%0d required 0/00010/6", cfg_valid_o, disp_valid_o, disp_vd_o);
        end
        edge_();
    endtask

    task automatic test_backpressure();
        do_reset();
        unit_ready_i = 5'b10111;
        drive(1, 3, 1, 1, 1, 0, 0, 1, 12, 13'h1ABC);
        cyc();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 30, 13'h0F0);
        for (int k = 0; k < 20; k++) begin
            settle();
            checks++;
            if (disp_valid_o !== 5'b01000 || disp_mode_o !== 13'h1ABC || disp_vd_o !== 5'd12 ||
                disp_vs1_o !== 5'd1 || disp_emul_o !== 2'd1 || instr_ready_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
                failures++;
                $display("FAIL bp_hold: disp=%b mode=%h vd=%0d vs1=%0d emul=%0d ready=%b stall=%0d required 01000/1abc/12/1/1/0/0",
                         disp_valid_o, disp_mode_o, disp_vd_o, disp_vs1_o, disp_emul_o, instr_ready_o, stall_cnt_o);
            end
            edge_();
        end
        unit_ready_i = '1;
        settle();
        checks++;
        if (disp_valid_o !== 5'b01000 || instr_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: disp=%b ready=%b required 01000/1", disp_valid_o, instr_ready_o);
        end
        edge_();
        instr_valid_i = 0;
        settle();
        checks++;
        if (pend_wr_o !== 32'h3000 || disp_valid_o !== 5'b00010 || disp_vd_o !== 5'd30) begin
            failures++;
            $display("FAIL bp_after: pend=%h disp=%b vd=%0d required 00003000/00010/30", pend_wr_o, disp_valid_o, disp_vd_o);
        end
        edge_();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 1, 1, 13'h0);
        cyc();
        instr_valid_i = 0;
        cyc();
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 13'h0);
        cyc();
        instr_valid_i = 0;
        repeat (65540) cyc();
        settle();
        checks++;
        if (stall_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_reach: stall=%h required ffff", stall_cnt_o);
        end
        edge_();
        repeat (3) cyc();
        settle();
        checks++;
        if (stall_cnt_o !== 16'hFFFF || disp_valid_o !== 5'b0) begin
            failures++;
            $display("FAIL sat_hold: stall=%h disp=%b required ffff/00000", stall_cnt_o, disp_valid_o);
        end
        edge_();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            sync_rst_ni = ($urandom % 80) != 0;
            drive(($urandom % 10) < 6, int'($urandom % 6), int'($urandom % 4),
                  bit'($urandom % 2), int'($urandom % 32), bit'($urandom % 2), int'($urandom % 32),
                  bit'($urandom % 2), int'($urandom % 32), 13'($urandom));
            wr_clear_i = (($urandom % 4) == 0) ? (m_pend & $urandom) : 32'h0;
            unit_ready_i = 5'($urandom);
            units_idle_i = (($urandom % 4) == 0) ? 5'($urandom) : 5'h1F;
            settle();
            checks++;
            if (instr_ready_o !== e_ready || disp_valid_o !== e_disp || cfg_valid_o !== e_cfg) begin
                failures++;
                $display("FAIL rand_ctrl cyc %0d: ready=%b disp=%b cfg=%b required %b/%b/%b",
                         k, instr_ready_o, disp_valid_o, cfg_valid_o, e_ready, e_disp, e_cfg);
            end
            checks++;
            if (pend_wr_o !== m_pend || stall_cnt_o !== m_stall) begin
                failures++;
                $display("FAIL rand_state cyc %0d: pend=%h stall=%0d required %h/%0d",
                         k, pend_wr_o, stall_cnt_o, m_pend, m_stall);
            end
            checks++;
            if (disp_mode_o !== m_mode || disp_emul_o !== m_emul || disp_vs1_o !== m_vs1 ||
                disp_vs2_o !== m_vs2 || disp_vd_o !== m_vd) begin
                failures++;
                $display("FAIL rand_data cyc %0d: mode=%h emul=%0d vs1=%0d vs2=%0d vd=%0d required %h/%0d/%0d/%0d/%0d",
                         k, disp_mode_o, disp_emul_o, disp_vs1_o, disp_vs2_o, disp_vd_o,
                         m_mode, m_emul, m_vs1, m_vs2, m_vd);
            end
            edge_();
        end
        sync_rst_ni = 1;
    endtask

    initial begin
        sync_rst_ni = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 13'h0);
        wr_clear_i = 0; unit_ready_i = '1; units_idle_i = '1;
        m_bv = 0; m_unit = 0; m_mode = 0; m_emul = 0; m_vs1v = 0; m_vs2v = 0; m_vdv = 0;
        m_vs1 = 0; m_vs2 = 0; m_vd = 0; m_pend = 0; m_stall = 0;
        #1;
        test_reset();
        test_streaming();
        test_raw();
        test_waw();
        test_cfg_drain();
        test_backpressure();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vproc_dispatcher.md
# vproc_dispatcher

In-order dispatcher between the vector decoder and the execution units (LSU, ALU, MUL, SLD, ELEM). It buffers one decoded instruction and tracks pending vector-register writes in a 32-bit bitmap. It holds the instruction back on read-after-write (RAW) or write-after-write (WAW) register-group hazards, then hands it to the selected unit. Configuration instructions (`UNIT_CFG`) are dispatched only after the whole vector pipeline has drained.

## Interface
Parameters:
- `UNIT_CNT`, 5: number of real units; unit index equals the `op_unit` encoding (`UNIT_LSU`=0 … `UNIT_ELEM`=4).
- `OP_W`, 13: width of the opaque `op_mode` payload.
- `STALL_W`, 16: width of the stall performance counter.

Ports:
- `clk_i`  in  1  clock. One clock domain; reset is synchronous and active-low.
- `sync_rst_ni`  in  1  synchronous active-low reset.
- `instr_valid_i`  in  1  decoded instruction valid.
- `instr_ready_o`  out  1  dispatcher accepts the instruction.
- `instr_unit_i`  in  3  target unit (`op_unit`).
- `instr_mode_i`  in  `OP_W`  `op_mode` payload, passed through unchanged.
- `instr_emul_i`  in  2  `cfg_emul`; group size is 1/2/4/8 registers.
- `instr_vs1_vreg_i`, `instr_vs2_vreg_i`, `instr_vd_vreg_i`  in  1 each  operand is a vector register.
- `instr_vs1_i`, `instr_vs2_i`, `instr_vd_i`  in  5 each  register addresses.
- `unit_ready_i`  in  `UNIT_CNT`  per-unit ready.
- `units_idle_i`  in  `UNIT_CNT`  per-unit idle (no instruction in flight).
- `wr_clear_i`  in  32  OR of the unit write-completion masks.
- `disp_valid_o`  out  `UNIT_CNT`  one-hot dispatch valid.
- `disp_mode_o`  out  `OP_W`  buffered payload.
- `disp_emul_o`  out  2  buffered EMUL.
- `disp_vs1_o`, `disp_vs2_o`, `disp_vd_o`  out  5 each  buffered addresses.
- `cfg_valid_o`  out  1  one-cycle pulse when a CFG instruction dispatches.
- `pend_wr_o`  out  32  pending-write bitmap.
- `stall_cnt_o`  out  `STALL_W`  saturating count of hazard/drain stall cycles.

## Operation
- **Buffer.** One entry (`buf_valid_q` plus fields). `instr_ready_o = !buf_valid_q | fire`.
  - Accept = `instr_valid_i & instr_ready_o`; it loads the buffer.
  - Fire without accept clears `buf_valid_q`.
- **Group mask.** `grp(a,e)` is a mask with `2^e` consecutive bits starting at `a & ~(2^e-1)`.
  - The address is aligned down. Misalignment is not checked here; the decoder rejects it.
- **Hazard.** `haz = (vs1_vreg & |(grp(vs1)&pend_q)) | (vs2_vreg & |(grp(vs2)&pend_q)) | (vd_vreg & |(grp(vd)&pend_q))`.
  - All terms are evaluated on buffer contents.
  - `pend_q` is the registered value. A same-cycle `wr_clear_i` does not unblock until the next cycle.
- **Non-CFG dispatch.**
  - `disp_valid_o[unit] = buf_valid_q & !haz`, other bits 0.
  - `fire = disp_valid_o[unit] & unit_ready_i[unit]`.
- **CFG dispatch.** `disp_valid_o` stays all 0.
  - `fire = buf_valid_q & (pend_q==0) & &units_idle_i`.
  - `cfg_valid_o = fire`.
- **Pending bitmap.** `pend_d = (pend_q & ~wr_clear_i) | (fire & !cfg & vd_vreg ? grp(vd,emul) : 0)`.
  - Clear is applied before set, so the set wins on overlap.
- **Stall counter.** Increments when `buf_valid_q & !fire & (haz | cfg-not-drained)`.
  - It does not increment when the only blocker is `!unit_ready_i`.
  - Saturates at all ones.
- A unit index ≥ `UNIT_CNT` that is not `UNIT_CFG` is illegal. It is never dispatched and blocks; the assertion must flag it.

## Timing
- **Reset values:**
  - `buf_valid_q=0`, `pend_q=0`, `stall_cnt=0`.
  - `instr_ready_o=1`, `disp_valid_o=0`, `cfg_valid_o=0`.
  - Data outputs are 0.
  - Reset mid-operation drops the buffered instruction and all pending bits.
- **Latency.** Accept in cycle N gives `disp_valid_o` in N+1 at the earliest. Fire in N+1 allows a new accept in N+1, so throughput is 1 per cycle.
- `disp_valid_o` never depends on `unit_ready_i`.
  - Once asserted, it and its data stay stable until fire, except on reset.
  - It can only rise (from hazard clear), never drop.
- **Back-to-back dependent instructions.** Writer fires in N, reader enters the buffer in N+1, reader sees `pend_q` set from N+1.
- **Clear-to-dispatch.** `wr_clear_i` in cycle M makes a blocked instruction dispatchable in M+1.

## Test plan
- **Reset:** hold `sync_rst_ni=0` for 2 cycles after loading an instruction. Required: `buf_valid_q=0`, `pend_wr_o=0`, `instr_ready_o=1`, `stall_cnt_o=0`.
- **Streaming:** ALU `vd=v4` emul 1, then MUL `vs2=v8` with all units ready. Required: dispatch in consecutive cycles, then `pend_wr_o=0x0000_0110`.
- **RAW across groups:** LSU `vd=v8` emul 4 (`pend=0x0000_0F00`), then ALU `vs1=v10` emul 1. Required: ALU blocked and `stall_cnt_o` counting. Pulse `wr_clear_i=0x0000_0F00` in cycle M; ALU `disp_valid_o[1]` in M+1.
- **WAW with clear/set collision:** `pend=0x1`, `wr_clear_i=0x1` in the same cycle another writer of `v0` fires. Required: `pend_wr_o` bit 0 remains 1.
- **CFG drain:** `pend=0x4` and MUL not idle, then CFG. Required: no `cfg_valid_o` until `pend=0` and `units_idle_i=5'b11111`; then a 1-cycle pulse, `disp_valid_o` stays 0, and the next instruction is accepted in the same cycle.
- **Backpressure and saturation:**
  - `unit_ready_i[3]=0` for 20 cycles on a hazard-free SLD. Required: valid and data stable, `stall_cnt_o` unchanged.
  - Force the counter to `0xFFFF` under hazard. Required: stays at `0xFFFF`.
